// File: rtl/asip_run_control_pkg.sv
// Shared FSM state encoding and sequencing constants for the ASIP run/debug controller.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        RESET = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        STEP  = 3'd4,
        HALT  = 3'd5
    } state_t;

    localparam int RESET_CYCLES = 2;

endpackage

// File: rtl/asip_run_control_button_conditioner.sv
// Active-low pushbutton -> 1-cycle press pulse (2-flop sync, falling edge); pulse follows the pin by 2 edges.
// Optional RUN_CTRL_DEBOUNCE_EN adds DEBOUNCE_CYCLES of stable-sample filtering before the edge detect.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_n,
    output logic o_press
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_level;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            r_prev  <= w_level;
        end
    end

`ifdef RUN_CTRL_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_stable;

    // The new level is adopted on its DEBOUNCE_CYCLES-th consecutive sample; any bounce restarts the count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b1;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_level = r_stable;
`else
    assign w_level = r_sync2;
`endif

    assign o_press = r_prev & ~w_level;

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_cfg_err
            $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
        end
    endgenerate

endmodule

// File: rtl/asip_run_control.sv
// Run/debug controller: button-driven OFF/RESET/RUN/PAUSE/STEP/HALT FSM producing a core clock enable.
// core_en is decoded combinationally (drops on the halt-match cycle); other outputs registered. Macro: RUN_CTRL_DEBOUNCE_EN.
module asip_run_control
    import run_ctrl_pkg::*;
#(
    parameter int N               = 24,
    parameter int STEP_CYCLES     = 1,
    parameter int CNT_W           = 32,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pwr,
    input  logic             i_stp,
    input  logic             i_dbg,
    input  logic [N-1:0]     i_pc,
    input  logic [N-1:0]     i_halt_addr,
    output logic             o_core_en,
    output logic             o_core_rst,
    output logic [2:0]       o_state,
    output logic             o_step_done,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_cycle_count
);

    localparam int SW = $clog2(STEP_CYCLES + 1);
    localparam int RW = $clog2(RESET_CYCLES + 1);

    state_t           r_state;
    state_t           w_next;
    logic [SW-1:0]    r_step_cnt;
    logic [RW-1:0]    r_rst_cnt;
    logic [CNT_W-1:0] r_cycle_count;
    logic             r_dbg_s1;
    logic             r_dbg_s2;
    logic             r_core_rst;
    logic             r_step_done;
    logic             r_halted;
    logic             w_pwr_press;
    logic             w_stp_press;
    logic             w_active;
    logic             w_hit;
    logic             w_core_en;
    logic             w_step_last;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pwr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn_n (i_pwr),
        .o_press (w_pwr_press)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stp (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn_n (i_stp),
        .o_press (w_stp_press)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= OFF;
        else       r_state <= w_next;
    end

    // Restart by pwr overrides everything except while already off or resetting.
    always_comb begin
        w_next = r_state;
        case (r_state)
            OFF:     if (w_pwr_press) w_next = RESET;
            RESET:   if (r_rst_cnt == RW'(RESET_CYCLES - 1)) w_next = r_dbg_s2 ? PAUSE : RUN;
            RUN:     if (w_hit) w_next = HALT;
                     else if (r_dbg_s2) w_next = PAUSE;
            PAUSE:   if (w_stp_press) w_next = STEP;
                     else if (!r_dbg_s2) w_next = RUN;
            STEP:    if (w_hit) w_next = HALT;
                     else if (w_step_last) w_next = r_dbg_s2 ? PAUSE : RUN;
            HALT:    w_next = HALT;
            default: w_next = OFF;
        endcase
        if (w_pwr_press && r_state != OFF && r_state != RESET) w_next = RESET;
    end

    always_comb begin
        w_active    = (r_state == RUN) || (r_state == STEP);
        w_hit       = w_active && (i_pc == i_halt_addr);
        w_core_en   = w_active && !w_hit;
        w_step_last = (r_state == STEP) && (r_step_cnt == SW'(1));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dbg_s1      <= 1'b0;
            r_dbg_s2      <= 1'b0;
            r_rst_cnt     <= '0;
            r_step_cnt    <= '0;
            r_cycle_count <= '0;
            r_core_rst    <= 1'b1;
            r_step_done   <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_dbg_s1 <= i_dbg;
            r_dbg_s2 <= r_dbg_s1;

            if (r_state == RESET) r_rst_cnt <= r_rst_cnt + 1'b1;
            else                  r_rst_cnt <= '0;

            if (r_state == PAUSE && w_next == STEP) r_step_cnt <= SW'(STEP_CYCLES);
            else if (r_state == STEP)               r_step_cnt <= r_step_cnt - 1'b1;

            if (r_state == RESET)                        r_cycle_count <= '0;
            else if (w_core_en && r_cycle_count != '1)   r_cycle_count <= r_cycle_count + 1'b1;

            r_core_rst  <= (w_next == OFF) || (w_next == RESET);
            r_halted    <= (w_next == HALT);
            // Only a step that actually completed (no halt, no restart) reports done.
            r_step_done <= (r_state == STEP) && (w_next == PAUSE || w_next == RUN);
        end
    end

    assign o_core_en     = w_core_en;
    assign o_core_rst    = r_core_rst;
    assign o_state       = r_state;
    assign o_step_done   = r_step_done;
    assign o_halted      = r_halted;
    assign o_cycle_count = r_cycle_count;

    generate
        if (STEP_CYCLES < 1) begin : g_cfg_err
            $error("asip_run_control: STEP_CYCLES must be >= 1");
        end
    endgenerate

endmodule

// File: tb/tb_asip_run_control.sv
// Directed bench for asip_run_control with STEP_CYCLES=3; debounce scenarios run when RUN_CTRL_DEBOUNCE_EN is defined.
module tb_asip_run_control;
    import run_ctrl_pkg::*;

`ifdef RUN_CTRL_DEBOUNCE_EN
    localparam int PL   = 3 + 16;
    localparam int HOLD = 20;
`else
    localparam int PL   = 3;
    localparam int HOLD = 5;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwr = 1'b1;
    logic        stp = 1'b1;
    logic        dbg = 1'b0;
    logic [23:0] pc = 24'h0;
    logic [23:0] halt_addr = 24'hFFFFFF;
    logic        core_en;
    logic        core_rst;
    logic [2:0]  state;
    logic        step_done;
    logic        halted;
    logic [31:0] cycle_count;

    int n_cmp = 0;
    int n_bad = 0;
    int en_total = 0;
    int sd_total = 0;
    int en_base;
    int sd_base;
    logic [31:0] cnt_snap;

    asip_run_control #(.N(24), .STEP_CYCLES(3), .CNT_W(32), .DEBOUNCE_CYCLES(16)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pwr         (pwr),
        .i_stp         (stp),
        .i_dbg         (dbg),
        .i_pc          (pc),
        .i_halt_addr   (halt_addr),
        .o_core_en     (core_en),
        .o_core_rst    (core_rst),
        .o_state       (state),
        .o_step_done   (step_done),
        .o_halted      (halted),
        .o_cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (core_en === 1'b1)   en_total++;
        if (step_done === 1'b1) sd_total++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        for (int i = 0; i < budget && state !== s; i++) tick();
        chk(tag, {29'b0, state}, {29'b0, s});
    endtask

    task automatic snap();
        en_base = en_total;
        sd_base = sd_total;
    endtask

    initial begin
        // 1: reset and idle
        tick(3);
        rst = 1'b0;
        tick(10);
        chk("rst_state", {29'b0, state}, 32'(OFF));
        chk("rst_core_en", {31'b0, core_en}, 32'd0);
        chk("rst_core_rst", {31'b0, core_rst}, 32'd1);
        chk("rst_count", cycle_count, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);

        // 2: power-up latency, two reset cycles, then run and count
        pwr = 1'b0;
        tick(PL - 1);
        chk("pwr_latency_off", {29'b0, state}, 32'(OFF));
        tick();
        chk("pwr_reset1", {29'b0, state}, 32'(RESET));
        chk("pwr_core_rst1", {31'b0, core_rst}, 32'd1);
        tick();
        chk("pwr_reset2", {29'b0, state}, 32'(RESET));
        tick();
        chk("run_state", {29'b0, state}, 32'(RUN));
        chk("run_core_en", {31'b0, core_en}, 32'd1);
        chk("run_core_rst", {31'b0, core_rst}, 32'd0);
        chk("run_count0", cycle_count, 32'd0);
        pwr = 1'b1;
        tick(10);
        chk("run_count10", cycle_count, 32'd10);
        chk("run_still", {29'b0, state}, 32'(RUN));

        // 3: debug pause and one 3-cycle step
        dbg = 1'b1;
        wait_state("pause_enter", PAUSE, 10);
        chk("pause_core_en", {31'b0, core_en}, 32'd0);
        tick(2);
        snap();
        cnt_snap = cycle_count;
        stp = 1'b0;
        tick(HOLD);
        stp = 1'b1;
        tick(30);
        chk("step_en_cycles", 32'(en_total - en_base), 32'd3);
        chk("step_done_cnt", 32'(sd_total - sd_base), 32'd1);
        chk("step_back_pause", {29'b0, state}, 32'(PAUSE));
        chk("step_count", cycle_count, cnt_snap + 32'd3);

        // 4: halt on PC match
        pc = 24'h00003E;
        halt_addr = 24'h000040;
        dbg = 1'b0;
        wait_state("halt_run", RUN, 10);
        tick();
        pc = 24'h00003F;
        #1;
        chk("halt_pre_en", {31'b0, core_en}, 32'd1);
        tick();
        pc = 24'h000040;
        #1;
        chk("halt_match_en", {31'b0, core_en}, 32'd0);
        cnt_snap = cycle_count;
        tick();
        chk("halt_state", {29'b0, state}, 32'(HALT));
        chk("halt_flag", {31'b0, halted}, 32'd1);
        snap();
        stp = 1'b0;
        tick(HOLD);
        stp = 1'b1;
        tick(30);
        chk("halt_stp_ignored", {29'b0, state}, 32'(HALT));
        chk("halt_no_en", 32'(en_total - en_base), 32'd0);
        chk("halt_count_frozen", cycle_count, cnt_snap);
        pc = 24'h0;
        pwr = 1'b0;
        wait_state("halt_pwr_reset", RESET, PL + 5);
        chk("halt_reset_rst", {31'b0, core_rst}, 32'd1);
        wait_state("halt_rerun", RUN, 5);
        chk("halt_rerun_count", cycle_count, 32'd0);
        chk("halt_cleared", {31'b0, halted}, 32'd0);
        pwr = 1'b1;

        // 5: simultaneous pwr+stp in PAUSE, then a long held step press
        dbg = 1'b1;
        wait_state("t5_pause", PAUSE, 10);
        tick(2);
        snap();
        pwr = 1'b0;
        stp = 1'b0;
        tick(PL);
        chk("t5_reset_wins", {29'b0, state}, 32'(RESET));
        tick(HOLD > PL ? HOLD - PL : 1);
        pwr = 1'b1;
        tick(50 - (HOLD > PL ? HOLD : PL + 1));
        stp = 1'b1;
        chk("t5_pause_again", {29'b0, state}, 32'(PAUSE));
        chk("t5_no_step_done", 32'(sd_total - sd_base), 32'd0);
        chk("t5_no_en", 32'(en_total - en_base), 32'd0);
        tick(30);
        snap();
        stp = 1'b0;
        tick(50);
        stp = 1'b1;
        tick(30);
        chk("t5_long_en", 32'(en_total - en_base), 32'd3);
        chk("t5_long_done", 32'(sd_total - sd_base), 32'd1);
        chk("t5_long_pause", {29'b0, state}, 32'(PAUSE));

`ifdef RUN_CTRL_DEBOUNCE_EN
        // 6: glitch rejection and debounced press
        snap();
        stp = 1'b0;
        tick(10);
        stp = 1'b1;
        tick(40);
        chk("db_glitch_en", 32'(en_total - en_base), 32'd0);
        chk("db_glitch_state", {29'b0, state}, 32'(PAUSE));
        snap();
        stp = 1'b0;
        tick(20);
        stp = 1'b1;
        tick(30);
        chk("db_press_en", 32'(en_total - en_base), 32'd3);
        chk("db_press_done", 32'(sd_total - sd_base), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
